// File: rtl/bti_ifetch.sv
// Instruction fetch unit: credit-limited prefetch over a split request/response bus
// into a small {pc,data} FIFO, with redirect flush and stale-response dropping.
module bti_ifetch #(
  parameter int              AW     = 32,
  parameter int              DW     = 32,
  parameter int              DEPTH  = 4,
  parameter logic [AW-1:0]   RST_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic          bti_req_vld_o,
  input  logic          bti_req_rdy_i,
  output logic [AW-1:0] bti_req_addr_o,
  input  logic          bti_rsp_vld_i,
  output logic          bti_rsp_rdy_o,
  input  logic [DW-1:0] bti_rsp_data_i,
  input  logic          redir_vld_i,
  input  logic [AW-1:0] redir_pc_i,
  output logic          inst_vld_o,
  input  logic          inst_rdy_i,
  output logic [DW-1:0] inst_data_o,
  output logic [AW-1:0] inst_pc_o
);

  localparam int             CW      = $clog2(DEPTH) + 1;
  localparam int             PW      = $clog2(DEPTH);
  localparam logic [CW:0]    DEPTH_C = (CW+1)'(DEPTH);

  logic [AW-1:0] fpc_q, fpc_d, rpc_q, rpc_d;
  logic [CW-1:0] osd_q, osd_d, drp_q, drp_d, cnt_q, cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] pc_mem_q   [DEPTH];
  logic [DW-1:0] data_mem_q [DEPTH];

  logic [CW:0]   used;
  logic          req_hs, rsp_hs, push, pop;
  logic [AW-1:0] target;
  logic          unused_redir_lsb;

  assign unused_redir_lsb = ^redir_pc_i[1:0];
  assign target = {redir_pc_i[AW-1:2], 2'b00};

  // Credit: never have more words in flight or buffered than the FIFO can hold.
  assign used           = {1'b0, osd_q} + {1'b0, cnt_q};
  assign bti_req_vld_o  = !rst && !redir_vld_i && (used < DEPTH_C);
  assign bti_req_addr_o = fpc_q;
  assign bti_rsp_rdy_o  = 1'b1;

  assign req_hs = bti_req_vld_o && bti_req_rdy_i;
  assign rsp_hs = bti_rsp_vld_i;
  assign push   = rsp_hs && (drp_q == '0) && !redir_vld_i;
  assign pop    = inst_vld_o && inst_rdy_i && !redir_vld_i;

  assign inst_vld_o  = (cnt_q != '0);
  assign inst_data_o = inst_vld_o ? data_mem_q[rd_ptr_q] : '0;
  assign inst_pc_o   = inst_vld_o ? pc_mem_q[rd_ptr_q]   : '0;

  always_comb begin
    fpc_d    = fpc_q;
    rpc_d    = rpc_q;
    drp_d    = drp_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    osd_d    = osd_q + CW'(req_hs) - CW'(rsp_hs);
    if (redir_vld_i) begin
      // Everything still in flight belongs to the old stream.
      fpc_d    = target;
      rpc_d    = target;
      cnt_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      drp_d    = rsp_hs ? osd_q - CW'(1) : osd_q;
    end else begin
      if (req_hs) fpc_d = fpc_q + AW'(4);
      if (push) begin
        rpc_d    = rpc_q + AW'(4);
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
      if (rsp_hs && (drp_q != '0)) drp_d = drp_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc_q    <= RST_PC;
      rpc_q    <= RST_PC;
      osd_q    <= '0;
      drp_q    <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      fpc_q    <= fpc_d;
      rpc_q    <= rpc_d;
      osd_q    <= osd_d;
      drp_q    <= drp_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= rpc_q;
      data_mem_q[wr_ptr_q] <= bti_rsp_data_i;
    end
  end

endmodule

// File: tb/tb_bti_ifetch.sv
// Directed bench for bti_ifetch: pipelined slave with selectable latency and a hold
// control, plus a second instance exercising address wrap from a high reset PC.
module tb_bti_ifetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_vld, req_rdy, rsp_vld, rsp_rdy;
  logic [31:0] req_addr, rsp_data;
  logic        redir_vld = 1'b0;
  logic [31:0] redir_pc  = '0;
  logic        inst_vld, inst_rdy;
  logic [31:0] inst_data, inst_pc;

  logic        w_req_vld, w_rsp_rdy, w_inst_vld;
  logic        w_rsp_vld;
  logic [31:0] w_req_addr, w_rsp_data, w_inst_data, w_inst_pc;

  int          lat  = 1;
  logic        hold = 1'b0;
  logic [2:0]  pv;
  logic [31:0] pa [0:2];
  int          cyc = 0;
  int          n_vec = 0, n_err = 0;

  int unsigned q_pc[$], q_data[$], q_cyc[$], w_pc[$], w_data[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  bti_ifetch dut (
    .clk(clk), .rst(rst),
    .bti_req_vld_o(req_vld), .bti_req_rdy_i(req_rdy), .bti_req_addr_o(req_addr),
    .bti_rsp_vld_i(rsp_vld), .bti_rsp_rdy_o(rsp_rdy), .bti_rsp_data_i(rsp_data),
    .redir_vld_i(redir_vld), .redir_pc_i(redir_pc),
    .inst_vld_o(inst_vld), .inst_rdy_i(inst_rdy),
    .inst_data_o(inst_data), .inst_pc_o(inst_pc)
  );

  bti_ifetch #(.RST_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst(rst),
    .bti_req_vld_o(w_req_vld), .bti_req_rdy_i(1'b1), .bti_req_addr_o(w_req_addr),
    .bti_rsp_vld_i(w_rsp_vld), .bti_rsp_rdy_o(w_rsp_rdy), .bti_rsp_data_i(w_rsp_data),
    .redir_vld_i(1'b0), .redir_pc_i(32'h0),
    .inst_vld_o(w_inst_vld), .inst_rdy_i(1'b1),
    .inst_data_o(w_inst_data), .inst_pc_o(w_inst_pc)
  );

  // Slave: in-order pipeline of depth lat; hold freezes it and masks both handshakes.
  assign req_rdy  = !hold;
  assign rsp_vld  = pv[lat-1] && !hold;
  assign rsp_data = mem_f(pa[lat-1]);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0;
    end else if (!hold) begin
      pv    <= {pv[1:0], req_vld && req_rdy};
      pa[2] <= pa[1];
      pa[1] <= pa[0];
      pa[0] <= req_addr;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      w_rsp_vld <= 1'b0;
    end else begin
      w_rsp_vld  <= w_req_vld;
      w_rsp_data <= mem_f(w_req_addr);
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && inst_vld && inst_rdy && !redir_vld) begin
      q_pc.push_back(inst_pc);
      q_data.push_back(inst_data);
      q_cyc.push_back(cyc);
    end
    if (!rst && w_inst_vld) begin
      w_pc.push_back(w_inst_pc);
      w_data.push_back(w_inst_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q_pc.delete(); q_data.delete(); q_cyc.delete(); w_pc.delete(); w_data.delete();
  endtask

  task automatic do_reset(input int l);
    rst = 1'b1; lat = l; hold = 1'b0; redir_vld = 1'b0; redir_pc = '0; inst_rdy = 1'b0;
    repeat (3) step();
    clear_q();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; inst_rdy = 1'b1;
    step(); step();
    n_vec++; if (req_vld !== 1'b0) begin n_err++; $display("FAIL rst_req_vld: got %b expected 0", req_vld); end
    n_vec++; if (inst_vld !== 1'b0) begin n_err++; $display("FAIL rst_inst_vld: got %b expected 0", inst_vld); end
    n_vec++; if (inst_pc !== 32'h0) begin n_err++; $display("FAIL rst_inst_pc: got %h expected 0", inst_pc); end
    n_vec++; if (inst_data !== 32'h0) begin n_err++; $display("FAIL rst_inst_data: got %h expected 0", inst_data); end
    n_vec++; if (dut.osd_q !== 3'd0 || dut.drp_q !== 3'd0 || dut.cnt_q !== 3'd0)
      begin n_err++; $display("FAIL rst_counters: got osd %0d drp %0d cnt %0d expected 0", dut.osd_q, dut.drp_q, dut.cnt_q); end
    n_vec++; if (u_wrap.fpc_q !== 32'hFFFF_FFF8) begin n_err++; $display("FAIL rst_wrap_fpc: got %h expected fffffff8", u_wrap.fpc_q); end
    rst = 1'b0;
    #1;
    n_vec++; if (req_vld !== 1'b1) begin n_err++; $display("FAIL first_req_vld: got %b expected 1", req_vld); end
    n_vec++; if (req_addr !== 32'h0) begin n_err++; $display("FAIL first_req_addr: got %h expected 0", req_addr); end
    n_vec++; if (w_req_addr !== 32'hFFFF_FFF8) begin n_err++; $display("FAIL first_wrap_addr: got %h expected fffffff8", w_req_addr); end
  endtask

  task automatic test_stream();
    do_reset(1);
    inst_rdy = 1'b1;
    repeat (24) step();
    for (int i = 0; i < 16; i++) begin
      n_vec++;
      if (i >= q_pc.size()) begin n_err++; $display("FAIL stream_pc[%0d]: got none expected %h", i, 4*i); end
      else begin
        if (q_pc[i] !== 32'(4*i)) begin n_err++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, q_pc[i], 4*i); end
        n_vec++;
        if (q_data[i] !== mem_f(32'(4*i))) begin n_err++; $display("FAIL stream_data[%0d]: got %h expected %h", i, q_data[i], mem_f(32'(4*i))); end
        n_vec++;
        if (q_cyc[i] !== q_cyc[0] + i) begin n_err++; $display("FAIL stream_gap[%0d]: got cycle %0d expected %0d", i, q_cyc[i], q_cyc[0] + i); end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset(1);
    inst_rdy = 1'b0;
    repeat (20) step();
    n_vec++; if (dut.cnt_q !== 3'd4) begin n_err++; $display("FAIL bp_cnt: got %0d expected 4", dut.cnt_q); end
    n_vec++; if (dut.osd_q !== 3'd0) begin n_err++; $display("FAIL bp_osd: got %0d expected 0", dut.osd_q); end
    n_vec++; if (req_vld !== 1'b0) begin n_err++; $display("FAIL bp_req_vld: got %b expected 0", req_vld); end
    n_vec++; if (inst_vld !== 1'b1 || inst_pc !== 32'h0) begin n_err++; $display("FAIL bp_head: got vld %b pc %h expected 1 0", inst_vld, inst_pc); end
    inst_rdy = 1'b1;
    repeat (12) step();
    for (int i = 0; i < 7; i++) begin
      n_vec++;
      if (i >= q_pc.size()) begin n_err++; $display("FAIL bp_pc[%0d]: got none expected %h", i, 4*i); end
      else if (q_pc[i] !== 32'(4*i) || q_data[i] !== mem_f(32'(4*i)))
        begin n_err++; $display("FAIL bp_word[%0d]: got pc %h data %h expected pc %h", i, q_pc[i], q_data[i], 4*i); end
    end
  endtask

  task automatic test_redirect();
    int k;
    do_reset(1);
    inst_rdy = 1'b0;
    k = 0;
    while (!(dut.cnt_q == 3'd3 && dut.osd_q == 3'd1) && k < 20) begin step(); k++; end
    n_vec++; if (k >= 20) begin n_err++; $display("FAIL redir_setup: got timeout expected cnt 3 osd 1"); end
    hold = 1'b1; redir_vld = 1'b1; redir_pc = 32'h103;
    step();
    hold = 1'b0; redir_vld = 1'b0;
    #1;
    n_vec++; if (inst_vld !== 1'b0) begin n_err++; $display("FAIL redir_flush: got inst_vld %b expected 0", inst_vld); end
    n_vec++; if (dut.drp_q !== 3'd1) begin n_err++; $display("FAIL redir_drp: got %0d expected 1", dut.drp_q); end
    n_vec++; if (req_vld !== 1'b1 || req_addr !== 32'h100) begin n_err++; $display("FAIL redir_req: got vld %b addr %h expected 1 100", req_vld, req_addr); end
    inst_rdy = 1'b1;
    repeat (8) step();
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (i >= q_pc.size()) begin n_err++; $display("FAIL redir_pc[%0d]: got none expected %h", i, 32'h100 + 4*i); end
      else if (q_pc[i] !== 32'h100 + 32'(4*i) || q_data[i] !== mem_f(32'h100 + 32'(4*i)))
        begin n_err++; $display("FAIL redir_word[%0d]: got pc %h data %h expected pc %h", i, q_pc[i], q_data[i], 32'h100 + 4*i); end
    end
  endtask

  task automatic test_redir_coincident();
    do_reset(2);
    inst_rdy = 1'b1;
    repeat (8) step();
    n_vec++; if (dut.osd_q !== 3'd2 || dut.cnt_q !== 3'd1 || rsp_vld !== 1'b1)
      begin n_err++; $display("FAIL coinc_setup: got osd %0d cnt %0d rsp %b expected 2 1 1", dut.osd_q, dut.cnt_q, rsp_vld); end
    redir_vld = 1'b1; redir_pc = 32'h400;
    step();
    redir_vld = 1'b0;
    clear_q();
    n_vec++; if (dut.drp_q !== 3'd1) begin n_err++; $display("FAIL coinc_drp: got %0d expected 1", dut.drp_q); end
    n_vec++; if (dut.cnt_q !== 3'd0 || inst_vld !== 1'b0) begin n_err++; $display("FAIL coinc_cnt: got cnt %0d vld %b expected 0 0", dut.cnt_q, inst_vld); end
    n_vec++; if (dut.osd_q !== 3'd1) begin n_err++; $display("FAIL coinc_osd: got %0d expected 1", dut.osd_q); end
    repeat (10) step();
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (i >= q_pc.size()) begin n_err++; $display("FAIL coinc_pc[%0d]: got none expected %h", i, 32'h400 + 4*i); end
      else if (q_pc[i] !== 32'h400 + 32'(4*i) || q_data[i] !== mem_f(32'h400 + 32'(4*i)))
        begin n_err++; $display("FAIL coinc_word[%0d]: got pc %h data %h expected pc %h", i, q_pc[i], q_data[i], 32'h400 + 4*i); end
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    do_reset(2);
    inst_rdy = 1'b1;
    repeat (8) step();
    n_vec++; if (dut.osd_q !== 3'd2) begin n_err++; $display("FAIL b2b_setup: got osd %0d expected 2", dut.osd_q); end
    redir_vld = 1'b1; redir_pc = 32'h200;
    step();
    n_vec++; if (dut.drp_q !== 3'd1 || dut.osd_q !== 3'd1) begin n_err++; $display("FAIL b2b_first: got drp %0d osd %0d expected 1 1", dut.drp_q, dut.osd_q); end
    redir_pc = 32'h300;
    step();
    redir_vld = 1'b0;
    clear_q();
    n_vec++; if (dut.drp_q !== 3'd0 || dut.osd_q !== 3'd0 || dut.fpc_q !== 32'h300)
      begin n_err++; $display("FAIL b2b_second: got drp %0d osd %0d fpc %h expected 0 0 300", dut.drp_q, dut.osd_q, dut.fpc_q); end
    repeat (10) step();
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (i >= q_pc.size()) begin n_err++; $display("FAIL b2b_pc[%0d]: got none expected %h", i, 32'h300 + 4*i); end
      else if (q_pc[i] !== 32'h300 + 32'(4*i) || q_data[i] !== mem_f(32'h300 + 32'(4*i)))
        begin n_err++; $display("FAIL b2b_word[%0d]: got pc %h data %h expected pc %h", i, q_pc[i], q_data[i], 32'h300 + 4*i); end
    end
    bad = 0;
    foreach (q_pc[i]) if (q_pc[i][31:8] == 24'h2) bad++;
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL b2b_stale: got %0d words from 0x200 stream expected 0", bad); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [4];
    exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0; exp_pc[3] = 32'h4;
    do_reset(1);
    repeat (10) step();
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (i >= w_pc.size()) begin n_err++; $display("FAIL wrap_pc[%0d]: got none expected %h", i, exp_pc[i]); end
      else if (w_pc[i] !== exp_pc[i] || w_data[i] !== mem_f(exp_pc[i]))
        begin n_err++; $display("FAIL wrap_word[%0d]: got pc %h data %h expected pc %h", i, w_pc[i], w_data[i], exp_pc[i]); end
    end
  endtask

  initial begin
    inst_rdy = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redir_coincident();
    test_back_to_back();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
